// File: rtl/joystick_spi_responder.sv
// joystick_spi_responder: SPI mode-0 responder that reports joystick position/buttons and accepts RGB LED commands.
module joystick_spi_responder #(
  parameter logic [7:0] LED_CMD     = 8'h84,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       CS_n,
  input  logic       SCK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [7:0] buttons,
  output logic [7:0] led_r,
  output logic [7:0] led_g,
  output logic [7:0] led_b,
  output logic       led_valid,
  output logic       frame_done,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_HIGH} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] cs_sh, sck_sh, mosi_sh;
  logic [SYNC_STAGES:0] prime;
  logic cs_s, sck_s, mosi_s, cs_d, sck_d;
  logic cs_fall, cs_rise, sck_fall, sck_rise, ready, start, stop;
  logic [39:0] tx;
  logic [6:0] rx;
  logic [7:0] cmd, p1, p2, p3, rx_byte;
  logic [5:0] bit_cnt;
  assign cs_s     = cs_sh[SYNC_STAGES-1];
  assign sck_s    = sck_sh[SYNC_STAGES-1];
  assign mosi_s   = mosi_sh[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;
  // The synchronizer resets to CS_n=1, so a high CS_n only counts once the chain holds real samples.
  assign ready    = prime[SYNC_STAGES];
  assign rx_byte  = {rx, mosi_s};
  assign busy     = state == ACTIVE;
  assign MISO     = busy & tx[39];
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      cs_sh   <= '1;
      sck_sh  <= '0;
      mosi_sh <= '0;
      cs_d    <= 1'b1;
      sck_d   <= 1'b0;
      prime   <= '0;
    end else begin
      cs_sh   <= {cs_sh[SYNC_STAGES-2:0], CS_n};
      sck_sh  <= {sck_sh[SYNC_STAGES-2:0], SCK};
      mosi_sh <= {mosi_sh[SYNC_STAGES-2:0], MOSI};
      cs_d    <= cs_s;
      sck_d   <= sck_s;
      prime   <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) state <= WAIT_HIGH;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    stop     = 1'b0;
    case (state)
      IDLE:    if (cs_fall) begin state_nx = ACTIVE; start = 1'b1; end
      ACTIVE:  if (cs_rise) begin state_nx = IDLE; stop = 1'b1; end
      default: if (ready && cs_s) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) begin
      tx         <= '0;
      rx         <= '0;
      bit_cnt    <= '0;
      {cmd, p1, p2, p3} <= '0;
      {led_r, led_g, led_b} <= '0;
      led_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      led_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (start) begin
        tx      <= {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], buttons};
        rx      <= '0;
        bit_cnt <= '0;
        {cmd, p1, p2, p3} <= '0;
      end else if (busy) begin
        if (sck_fall) tx <= {tx[38:0], 1'b0};
        if (sck_rise) begin
          rx <= rx_byte[6:0];
          if (bit_cnt < 6'd40) begin
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt[2:0] == 3'd7) begin
              if (bit_cnt[5:3] == 3'd0) cmd <= rx_byte;
              if (bit_cnt[5:3] == 3'd1) p1 <= rx_byte;
              if (bit_cnt[5:3] == 3'd2) p2 <= rx_byte;
              if (bit_cnt[5:3] == 3'd3) p3 <= rx_byte;
            end
          end
        end
        if (stop) begin
          frame_done <= 1'b1;
          if (bit_cnt >= 6'd32 && cmd == LED_CMD) begin
            {led_r, led_g, led_b} <= {p1, p2, p3};
            led_valid <= 1'b1;
          end
        end
      end
    end
endmodule
